// File: rtl/uart_rx_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_word_assembler
// Description : Packs received UART bytes little-endian into words and
//               presents each word on a valid/ready output register.
//               Discards a partial word after an inter-byte timeout, flags
//               bytes dropped while blocked, and supports a synchronous
//               flush.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_word_assembler #(
    parameter int DATA_BITS     = 8,
    parameter int WORD_BYTES    = 4,
    parameter int TIMEOUT_TICKS = 352
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic                                i_rx_done,
    input  logic [DATA_BITS-1:0]                i_rx_data,
    input  logic                                i_bd_tick,
    input  logic                                i_clear,
    output logic [DATA_BITS*WORD_BYTES-1:0]     o_word,
    output logic                                o_word_valid,
    input  logic                                i_word_ready,
    output logic [$clog2(WORD_BYTES+1)-1:0]     o_byte_count,
    output logic                                o_overrun,
    output logic                                o_timeout
);

    localparam int c_WORD_W  = DATA_BITS * WORD_BYTES;
    localparam int c_COUNT_W = $clog2(WORD_BYTES + 1);
    localparam int c_TO_W    = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [c_COUNT_W-1:0] c_FULL_COUNT = c_COUNT_W'(WORD_BYTES);
    localparam logic [c_COUNT_W-1:0] c_COUNT_ONE  = c_COUNT_W'(1);
    localparam logic [c_TO_W-1:0]    c_TO_LAST    = c_TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [c_TO_W-1:0]    c_TO_ONE     = c_TO_W'(1);

    // State encoding
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_ASSEMBLE = 2'd1;
    localparam logic [1:0] c_ST_PENDING  = 2'd2;

    logic [1:0]           r_state;
    logic [c_WORD_W-1:0]  r_shreg;
    logic [c_COUNT_W-1:0] r_count;
    logic [c_TO_W-1:0]    r_to_cnt;
    logic [c_WORD_W-1:0]  r_word;
    logic                 r_word_valid;
    logic                 r_overrun;
    logic                 r_timeout;

    logic [c_WORD_W-1:0]  w_shifted;
    logic [c_COUNT_W-1:0] w_count_inc;
    logic                 w_word_done;
    logic                 w_slot_free;
    logic                 w_accept;

    // New byte enters at the top; earlier bytes move toward the LSBs so the
    // first byte of a word finishes in the lowest byte lane.
    assign w_shifted   = (r_shreg >> DATA_BITS)
                       | (c_WORD_W'(i_rx_data) << (c_WORD_W - DATA_BITS));
    assign w_count_inc = r_count + c_COUNT_ONE;
    assign w_word_done = (w_count_inc == c_FULL_COUNT);
    assign w_accept    = r_word_valid && i_word_ready;
    // The output slot can take a new word if empty or being drained now.
    assign w_slot_free = !r_word_valid || i_word_ready;

    // Assembler FSM with the output register, overrun and timeout flags.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= c_ST_IDLE;
            r_shreg      <= '0;
            r_count      <= '0;
            r_to_cnt     <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (i_clear) begin
            // Flush wins over everything, including a coincident byte.
            r_state      <= c_ST_IDLE;
            r_shreg      <= '0;
            r_count      <= '0;
            r_to_cnt     <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (w_accept) begin
                r_word_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE, c_ST_ASSEMBLE: begin
                    if (i_rx_done) begin
                        // A byte always beats an expiring tick.
                        r_shreg  <= w_shifted;
                        r_to_cnt <= '0;
                        if (w_word_done) begin
                            if (w_slot_free) begin
                                r_word       <= w_shifted;
                                r_word_valid <= 1'b1;
                                r_count      <= '0;
                                r_state      <= c_ST_IDLE;
                            end else begin
                                r_count <= c_FULL_COUNT;
                                r_state <= c_ST_PENDING;
                            end
                        end else begin
                            r_count <= w_count_inc;
                            r_state <= c_ST_ASSEMBLE;
                        end
                    end else if ((r_state == c_ST_ASSEMBLE) && i_bd_tick) begin
                        if (r_to_cnt == c_TO_LAST) begin
                            // Sender stalled mid-word: drop the fragment.
                            r_shreg   <= '0;
                            r_count   <= '0;
                            r_to_cnt  <= '0;
                            r_timeout <= 1'b1;
                            r_state   <= c_ST_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_TO_ONE;
                        end
                    end
                end

                c_ST_PENDING: begin
                    // Full word waiting for the slot; any new byte is lost.
                    if (i_rx_done) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_accept) begin
                        r_word       <= r_shreg;
                        r_word_valid <= 1'b1;
                        r_count      <= '0;
                        r_state      <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state  <= c_ST_IDLE;
                    r_count  <= '0;
                    r_to_cnt <= '0;
                end
            endcase
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_byte_count = r_count;
    assign o_overrun    = r_overrun;
    assign o_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_word_assembler
// Description : Directed, table-driven self-checking bench for
//               uart_rx_word_assembler, plus hand-written timeout, flush
//               and asynchronous reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word_assembler;

    logic        clk;
    logic        rst_n;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        bd_tick;
    logic        clear;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  byte_count;
    logic        overrun;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    uart_rx_word_assembler #(
        .DATA_BITS     (8),
        .WORD_BYTES    (4),
        .TIMEOUT_TICKS (352)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_bd_tick    (bd_tick),
        .i_clear      (clear),
        .o_word       (word),
        .o_word_valid (word_valid),
        .i_word_ready (word_ready),
        .o_byte_count (byte_count),
        .o_overrun    (overrun),
        .o_timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rx;
        logic [7:0]  data;
        logic        tick;
        logic        clr;
        logic        rdy;
        logic [31:0] e_word;
        logic        chk_word;
        logic        e_valid;
        logic [2:0]  e_cnt;
        logic        e_ovr;
        logic        e_to;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add_vec(input logic rx, input logic [7:0] data, input logic tick,
                           input logic clr, input logic rdy, input logic [31:0] e_word,
                           input logic chk_word, input logic e_valid, input logic [2:0] e_cnt,
                           input logic e_ovr, input logic e_to);
        vecs[nvec] = {rx, data, tick, clr, rdy, e_word, chk_word, e_valid, e_cnt, e_ovr, e_to};
        nvec++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rx, input logic [7:0] data, input logic tick,
                         input logic clr, input logic rdy);
        rx_done    = rx;
        rx_data    = data;
        bd_tick    = tick;
        clear      = clr;
        word_ready = rdy;
    endtask

    // Apply the current inputs across one rising edge, then settle.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int to_pulses;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // ---------------- vector table ----------------
        //       rx  data   tk clr rdy  e_word        chk valid cnt ovr to
        // Word 0x12345678, ready high: valid one cycle after 4th byte.
        add_vec(1, 8'h78, 0, 0, 1, 32'h0,        0, 0, 3'd1, 0, 0);
        add_vec(1, 8'h56, 0, 0, 1, 32'h0,        0, 0, 3'd2, 0, 0);
        add_vec(1, 8'h34, 0, 0, 1, 32'h0,        0, 0, 3'd3, 0, 0);
        add_vec(1, 8'h12, 0, 0, 1, 32'h12345678, 1, 1, 3'd0, 0, 0);
        add_vec(0, 8'h00, 0, 0, 1, 32'h0,        0, 0, 3'd0, 0, 0);
        // Ready low: first word held, second word parks in PENDING.
        add_vec(1, 8'h01, 0, 0, 0, 32'h0,        0, 0, 3'd1, 0, 0);
        add_vec(1, 8'h02, 0, 0, 0, 32'h0,        0, 0, 3'd2, 0, 0);
        add_vec(1, 8'h03, 0, 0, 0, 32'h0,        0, 0, 3'd3, 0, 0);
        add_vec(1, 8'h04, 0, 0, 0, 32'h04030201, 1, 1, 3'd0, 0, 0);
        add_vec(1, 8'h05, 0, 0, 0, 32'h04030201, 1, 1, 3'd1, 0, 0);
        add_vec(1, 8'h06, 0, 0, 0, 32'h04030201, 1, 1, 3'd2, 0, 0);
        add_vec(1, 8'h07, 0, 0, 0, 32'h04030201, 1, 1, 3'd3, 0, 0);
        add_vec(1, 8'h08, 0, 0, 0, 32'h04030201, 1, 1, 3'd4, 0, 0);
        add_vec(0, 8'h00, 0, 0, 0, 32'h04030201, 1, 1, 3'd4, 0, 0);
        add_vec(0, 8'h00, 0, 0, 1, 32'h08070605, 1, 1, 3'd0, 0, 0);
        add_vec(0, 8'h00, 0, 0, 0, 32'h08070605, 1, 1, 3'd0, 0, 0);
        // Fill PENDING again, then a dropped byte sets sticky overrun.
        add_vec(1, 8'h11, 0, 0, 0, 32'h08070605, 1, 1, 3'd1, 0, 0);
        add_vec(1, 8'h22, 0, 0, 0, 32'h08070605, 1, 1, 3'd2, 0, 0);
        add_vec(1, 8'h33, 0, 0, 0, 32'h08070605, 1, 1, 3'd3, 0, 0);
        add_vec(1, 8'h44, 0, 0, 0, 32'h08070605, 1, 1, 3'd4, 0, 0);
        add_vec(1, 8'hAA, 0, 0, 0, 32'h08070605, 1, 1, 3'd4, 1, 0);
        add_vec(0, 8'h00, 0, 0, 1, 32'h44332211, 1, 1, 3'd0, 1, 0);
        add_vec(0, 8'h00, 0, 0, 1, 32'h0,        0, 0, 3'd0, 1, 0);
        // Flush clears the sticky flag and the output register.
        add_vec(0, 8'h00, 0, 1, 0, 32'h0,        1, 0, 3'd0, 0, 0);
        add_vec(0, 8'h00, 0, 0, 0, 32'h0,        1, 0, 3'd0, 0, 0);
        // Flush coincident with the final byte: no word, no overrun.
        add_vec(1, 8'hA1, 0, 0, 1, 32'h0,        0, 0, 3'd1, 0, 0);
        add_vec(1, 8'hA2, 0, 0, 1, 32'h0,        0, 0, 3'd2, 0, 0);
        add_vec(1, 8'hA3, 0, 0, 1, 32'h0,        0, 0, 3'd3, 0, 0);
        add_vec(1, 8'hA4, 0, 1, 1, 32'h0,        1, 0, 3'd0, 0, 0);
        add_vec(0, 8'h00, 0, 0, 1, 32'h0,        1, 0, 3'd0, 0, 0);
        // Ticks while idle do nothing.
        add_vec(0, 8'h00, 1, 0, 1, 32'h0,        1, 0, 3'd0, 0, 0);

        // ---------------- reset state ----------------
        #12;
        check("reset word",    word,       32'h0);
        check("reset valid",   word_valid, 1'b0);
        check("reset count",   byte_count, 3'd0);
        check("reset overrun", overrun,    1'b0);
        check("reset timeout", timeout,    1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // ---------------- table ----------------
        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].rx, vecs[i].data, vecs[i].tick, vecs[i].clr, vecs[i].rdy);
            cycle();
            if (vecs[i].chk_word)
                check($sformatf("v%0d word", i), word, vecs[i].e_word);
            check($sformatf("v%0d valid", i),   word_valid, vecs[i].e_valid);
            check($sformatf("v%0d count", i),   byte_count, vecs[i].e_cnt);
            check($sformatf("v%0d overrun", i), overrun,    vecs[i].e_ovr);
            check($sformatf("v%0d timeout", i), timeout,    vecs[i].e_to);
        end

        // ---------------- timeout after 352 ticks ----------------
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b1); cycle();
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b1); cycle();
        to_pulses = 0;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int t = 0; t < 351; t++) begin
            cycle();
            if (timeout) to_pulses++;
        end
        check("to early pulses", to_pulses, 0);
        check("to count before", byte_count, 3'd2);
        cycle();
        check("to pulse", timeout, 1'b1);
        check("to count cleared", byte_count, 3'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); cycle();
        check("to pulse width", timeout, 1'b0);
        drive(1'b1, 8'hDD, 1'b0, 1'b0, 1'b1); cycle();
        drive(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1); cycle();
        drive(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1); cycle();
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1); cycle();
        check("post-to word", word, 32'hAABBCCDD);
        check("post-to valid", word_valid, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); cycle();
        check("post-to drained", word_valid, 1'b0);

        // ---------------- byte coincident with expiring tick ----------------
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1); cycle();
        drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b1); cycle();
        to_pulses = 0;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int t = 0; t < 351; t++) begin
            cycle();
            if (timeout) to_pulses++;
        end
        drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b1); cycle();
        if (timeout) to_pulses++;
        check("race no timeout", to_pulses, 0);
        check("race count", byte_count, 3'd3);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // ---------------- async reset mid-word ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check("areset word",    word,       32'h0);
        check("areset valid",   word_valid, 1'b0);
        check("areset count",   byte_count, 3'd0);
        check("areset overrun", overrun,    1'b0);
        check("areset timeout", timeout,    1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("after areset count", byte_count, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_word_assembler.md
Name: uart_rx_word_assembler

Overview:
Sits directly downstream of the UART receiver. It consumes one received byte per rx_done pulse and packs WORD_BYTES bytes, little-endian, into one word. The word is presented on a valid/ready output register to the debug/loader logic that writes instruction and data memory. It also provides inter-byte timeout recovery, overrun detection and a synchronous flush.

Parameters:
DATA_BITS, 8, width of one received byte (matches receiver data width in byte mode)
WORD_BYTES, 4, bytes per assembled word; output width = DATA_BITS*WORD_BYTES
TIMEOUT_TICKS, 352, baud ticks (16x oversample) allowed between bytes of one word before the partial word is discarded (2 frame times)

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_rx_done  input  1  one-cycle pulse from receiver: i_rx_data valid this cycle
i_rx_data  input  DATA_BITS  received byte
i_bd_tick  input  1  baud-rate generator tick (same tick fed to receiver)
i_clear  input  1  synchronous flush of all state and flags
o_word  output  DATA_BITS*WORD_BYTES  assembled word, valid while o_word_valid
o_word_valid  output  1  output slot holds a word
i_word_ready  input  1  consumer accepts word when high with o_word_valid
o_byte_count  output  clog2(WORD_BYTES+1)  bytes held in the partial word (0..WORD_BYTES)
o_overrun  output  1  sticky: byte dropped because assembler was blocked
o_timeout  output  1  one-cycle pulse: partial word discarded on timeout

Behaviour:
- Async reset (i_reset_n=0), and i_clear=1 at a clock edge: state IDLE, shift reg 0, byte count 0, timeout counter 0, o_word=0, o_word_valid=0, o_overrun=0, o_timeout=0. i_clear overrides every other input that cycle; a simultaneous rx_done byte is dropped and not counted as overrun.
- Packing: each accepted byte does shreg <= {i_rx_data, shreg[W-1:DATA_BITS]}. First byte of a word ends in o_word[DATA_BITS-1:0]; last byte ends in the MSBs.
- Transfer: handshake completes on a cycle with o_word_valid && i_word_ready. o_word is stable while o_word_valid=1 and not accepted.
- FSM states:
  - IDLE (count=0): rx_done -> accept byte, count=1, go to ASSEMBLE. Timeout counter is held at 0.
  - ASSEMBLE (0<count<WORD_BYTES): rx_done -> accept byte, count+1, timeout counter reset to 0.
    - If this byte completes the word and the slot is free (o_word_valid=0, or being accepted this cycle): load o_word, set o_word_valid=1 on the next edge, count=0, go to IDLE. Latency is 1 cycle from the final rx_done to valid.
    - If it completes the word and the slot is occupied and not accepted: go to PENDING with count=WORD_BYTES.
    - Else, on i_bd_tick the timeout counter increments. On the tick where the counter = TIMEOUT_TICKS-1: discard the partial word, count=0, shreg=0, pulse o_timeout one cycle, go to IDLE.
    - rx_done and the expiring tick in the same cycle: the byte wins, no timeout.
  - PENDING (count=WORD_BYTES): timeout is not counted. rx_done -> byte dropped, o_overrun set (sticky until reset/clear). On a cycle where the slot is accepted: load o_word from shreg next edge, o_word_valid stays 1, count=0, go to IDLE. A byte arriving in that same cycle is dropped and flagged as overrun.
- o_word_valid clears on acceptance unless reloaded the same edge. Back-to-back words are sustained with ready tied high.
- i_rx_data is sampled only when i_rx_done=1. i_bd_tick is ignored outside ASSEMBLE.
- All outputs are registered except o_byte_count, which reflects the count register directly.

Test Plan:
- Reset then bytes 0x78,0x56,0x34,0x12 with i_word_ready=1 -> o_word=0x12345678, o_word_valid high exactly 1 cycle, one cycle after the 4th rx_done; o_byte_count walks 1,2,3,0.
- Ready held 0; send 8 bytes 0x01..0x08 -> first word 0x04030201 held stable; after 4th byte of second word, count=4 (PENDING); raise ready one cycle -> next cycle o_word=0x08070605, valid stays 1; o_overrun=0.
- In PENDING send 9th byte 0xAA -> o_overrun=1 and stays 1; 0xAA not in any later word; i_clear -> o_overrun=0, o_word_valid=0, count=0.
- Send 2 bytes, then 352 baud ticks with no rx_done -> o_timeout pulses once, count=0; then 4 new bytes 0xDD,0xCC,0xBB,0xAA -> o_word=0xAABBCCDD (no stale bytes).
- rx_done coincident with the 352nd tick -> no o_timeout, count increments. Assert i_reset_n=0 mid-word (count=3) -> all outputs 0 immediately, without waiting for a clock edge.
- i_clear coincident with the final rx_done of a word -> no o_word_valid, o_overrun stays 0, count=0.
